bcd_clock_display: RTL

- Parametrised successor to the board-level digital clock.
- Keeps a 24-hour BCD time-of-day (HH:MM:SS) advanced by an internal tick divider.
- Supports run/hold, field-by-field time setting and an optional 12-hour display mode.
- Time-multiplexes all digits onto one shared seven-segment bus with one-hot digit enables. Top-level block driving the board display.

---
 rtl/bcd_clock_pkg.sv | 65 ++++++
 rtl/bcd_clock_display_if.sv | 29 ++
 rtl/seg7_decode.sv | 25 ++
 rtl/bcd_clock_display.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/bcd_clock_pkg.sv
// Shared definitions for the BCD time-of-day clock display.
// Holds the active-low seven-segment patterns ({g,f,e,d,c,b,a}), the blank
// digit code, the set_sel field encodings, the digit-position map, the
// packed BCD time record and the BCD increment helpers used by the time
// counter.
package bcd_clock_pkg;

    localparam logic [6:0] SEG_0     = 7'h40;
    localparam logic [6:0] SEG_1     = 7'h79;
    localparam logic [6:0] SEG_2     = 7'h24;
    localparam logic [6:0] SEG_3     = 7'h30;
    localparam logic [6:0] SEG_4     = 7'h19;
    localparam logic [6:0] SEG_5     = 7'h12;
    localparam logic [6:0] SEG_6     = 7'h02;
    localparam logic [6:0] SEG_7     = 7'h78;
    localparam logic [6:0] SEG_8     = 7'h00;
    localparam logic [6:0] SEG_9     = 7'h10;
    localparam logic [6:0] SEG_BLANK = 7'h7F;

    // Any code 10..15 decodes to blank; this one is used by the digit mux.
    localparam logic [3:0] CODE_BLANK = 4'hF;

    typedef enum logic [1:0] {
        SEL_RUN = 2'd0,
        SEL_HR  = 2'd1,
        SEL_MIN = 2'd2,
        SEL_SEC = 2'd3
    } set_sel_e;

    localparam int unsigned DIG_SEC_O = 0;
    localparam int unsigned DIG_SEC_T = 1;
    localparam int unsigned DIG_MIN_O = 2;
    localparam int unsigned DIG_MIN_T = 3;
    localparam int unsigned DIG_HR_O  = 4;
    localparam int unsigned DIG_HR_T  = 5;

    typedef struct packed {
        logic [3:0] hr_t;
        logic [3:0] hr_o;
        logic [3:0] min_t;
        logic [3:0] min_o;
        logic [3:0] sec_t;
        logic [3:0] sec_o;
    } bcd_time_t;

    // {tens, ones} + 1 with wrap 59 -> 00.
    function automatic logic [7:0] bcd_inc_60(input logic [7:0] v);
        if (v[3:0] == 4'd9) begin
            return (v[7:4] == 4'd5) ? 8'h00 : {v[7:4] + 4'd1, 4'd0};
        end
        return {v[7:4], v[3:0] + 4'd1};
    endfunction

    // {tens, ones} + 1 with wrap 23 -> 00.
    function automatic logic [7:0] bcd_inc_24(input logic [7:0] v);
        if (v == 8'h23) begin
            return 8'h00;
        end
        if (v[3:0] == 4'd9) begin
            return {v[7:4] + 4'd1, 4'd0};
        end
        return {v[7:4], v[3:0] + 4'd1};
    endfunction

endpackage

// File: rtl/bcd_clock_display_if.sv
// Control and display bundle of the BCD clock.
//   run, mode_12h, set_sel[1:0], inc : control inputs to the clock
//   SSD[6:0], EN[NUM_DIGITS-1:0], dp : multiplexed active-low display
//   pm, tick, bcd_time[23:0]         : status outputs
// master drives the controls (board/testbench); slave is the clock.
interface bcd_clock_display_if #(
    parameter int unsigned NUM_DIGITS = 8
);
    logic                  run;
    logic                  mode_12h;
    logic [1:0]            set_sel;
    logic                  inc;
    logic [6:0]            SSD;
    logic [NUM_DIGITS-1:0] EN;
    logic                  dp;
    logic                  pm;
    logic                  tick;
    logic [23:0]           bcd_time;

    modport master (
        output run, mode_12h, set_sel, inc,
        input  SSD, EN, dp, pm, tick, bcd_time
    );

    modport slave (
        input  run, mode_12h, set_sel, inc,
        output SSD, EN, dp, pm, tick, bcd_time
    );
endinterface

// File: rtl/seg7_decode.sv
// Combinational BCD to seven-segment decoder.
//   code[3:0] : digit value; 10..15 give a blank digit
//   seg[6:0]  : {g,f,e,d,c,b,a}, active-low
module seg7_decode (
    input  logic [3:0] code,
    output logic [6:0] seg
);
    import bcd_clock_pkg::*;

    always_comb begin
        case (code)
            4'd0:    seg = SEG_0;
            4'd1:    seg = SEG_1;
            4'd2:    seg = SEG_2;
            4'd3:    seg = SEG_3;
            4'd4:    seg = SEG_4;
            4'd5:    seg = SEG_5;
            4'd6:    seg = SEG_6;
            4'd7:    seg = SEG_7;
            4'd8:    seg = SEG_8;
            4'd9:    seg = SEG_9;
            default: seg = SEG_BLANK;
        endcase
    end
endmodule

// File: rtl/bcd_clock_display.sv
// 24-hour BCD time-of-day clock driving a multiplexed seven-segment display.
// Ports:
//   clk : system clock
//   rst : asynchronous reset, active-low
//   bus : bcd_clock_display_if.slave (run/mode_12h/set_sel/inc in;
//         SSD/EN/dp/pm/tick/bcd_time out)
// Optional build macro SET_BLINK_EN: while a field is being set, its digits
// are blanked whenever the seconds-ones digit is odd.
module bcd_clock_display #(
    parameter int unsigned CLK_HZ     = 100000000,
    parameter int unsigned TICK_HZ    = 1,
    parameter int unsigned SCAN_HZ    = 1000,
    parameter int unsigned NUM_DIGITS = 8
) (
    input logic               clk,
    input logic               rst,
    bcd_clock_display_if.slave bus
);
    import bcd_clock_pkg::*;

    localparam int unsigned TICK_DIV = CLK_HZ / TICK_HZ;
    localparam int unsigned SCAN_DIV = CLK_HZ / SCAN_HZ;
    localparam int unsigned TW       = $clog2(TICK_DIV);
    localparam int unsigned SW       = $clog2(SCAN_DIV);
    localparam int unsigned DW       = $clog2(NUM_DIGITS);

    set_sel_e sel;
    assign sel = set_sel_e'(bus.set_sel);

    // ---------------- tick divider ----------------
    logic [TW-1:0] tdiv;
    logic          tick_int;

    assign tick_int = (tdiv == TW'(TICK_DIV - 1));
    assign bus.tick = tick_int;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tdiv <= '0;
        end else if (sel != SEL_RUN || tick_int) begin
            tdiv <= '0;
        end else begin
            tdiv <= tdiv + TW'(1);
        end
    end

    // ---------------- inc edge detect ----------------
    logic inc_q;
    logic inc_edge;

    assign inc_edge = bus.inc & ~inc_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            inc_q <= 1'b0;
        end else begin
            inc_q <= bus.inc;
        end
    end

    // ---------------- time counter ----------------
    bcd_time_t  cur;
    bcd_time_t  nxt;
    logic [7:0] sec;
    logic [7:0] min;
    logic [7:0] hr;

    assign sec = {cur.sec_t, cur.sec_o};
    assign min = {cur.min_t, cur.min_o};
    assign hr  = {cur.hr_t,  cur.hr_o};

    // Whole carry chain resolved in one comb pass so the register only ever
    // loads legal BCD, including 23:59:59 -> 00:00:00.
    always_comb begin
        nxt = cur;
        if (sel == SEL_RUN) begin
            if (tick_int && bus.run) begin
                {nxt.sec_t, nxt.sec_o} = bcd_inc_60(sec);
                if (sec == 8'h59) begin
                    {nxt.min_t, nxt.min_o} = bcd_inc_60(min);
                    if (min == 8'h59) begin
                        {nxt.hr_t, nxt.hr_o} = bcd_inc_24(hr);
                    end
                end
            end
        end else if (inc_edge) begin
            case (sel)
                SEL_HR:  {nxt.hr_t,  nxt.hr_o}  = bcd_inc_24(hr);
                SEL_MIN: {nxt.min_t, nxt.min_o} = bcd_inc_60(min);
                SEL_SEC: {nxt.sec_t, nxt.sec_o} = 8'h00;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cur <= '0;
        end else begin
            cur <= nxt;
        end
    end

    assign bus.bcd_time = cur;

    // ---------------- hour display / pm ----------------
    logic [4:0] hr_bin;
    logic [4:0] disp_bin;
    logic [3:0] disp_t;
    logic [3:0] disp_o;

    assign hr_bin = 5'(cur.hr_t) * 5'd10 + 5'(cur.hr_o);
    assign bus.pm = (hr_bin >= 5'd12);

    always_comb begin
        if (!bus.mode_12h) begin
            disp_bin = hr_bin;
        end else if (hr_bin == 5'd0) begin
            disp_bin = 5'd12;
        end else if (hr_bin > 5'd12) begin
            disp_bin = hr_bin - 5'd12;
        end else begin
            disp_bin = hr_bin;
        end

        if (disp_bin >= 5'd20) begin
            disp_t = 4'd2;
            disp_o = 4'(disp_bin - 5'd20);
        end else if (disp_bin >= 5'd10) begin
            disp_t = 4'd1;
            disp_o = 4'(disp_bin - 5'd10);
        end else begin
            disp_t = (bus.mode_12h) ? CODE_BLANK : 4'd0;
            disp_o = disp_bin[3:0];
        end
    end

    // ---------------- scan ----------------
    logic [SW-1:0] sdiv;
    logic [DW-1:0] d;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sdiv <= '0;
            d    <= '0;
        end else if (sdiv == SW'(SCAN_DIV - 1)) begin
            sdiv <= '0;
            d    <= (d == DW'(NUM_DIGITS - 1)) ? '0 : d + DW'(1);
        end else begin
            sdiv <= sdiv + SW'(1);
        end
    end

    int unsigned           di;
    logic [3:0]            code;
    logic [6:0]            seg;
    logic [NUM_DIGITS-1:0] en_next;
    logic                  dp_next;

    assign di = 32'(d);

    always_comb begin
        code = CODE_BLANK;
        case (di)
            DIG_SEC_O: code = cur.sec_o;
            DIG_SEC_T: code = cur.sec_t;
            DIG_MIN_O: code = cur.min_o;
            DIG_MIN_T: code = cur.min_t;
            DIG_HR_O:  code = disp_o;
            DIG_HR_T:  code = disp_t;
            default:   code = CODE_BLANK;
        endcase
`ifdef SET_BLINK_EN
        if (sel != SEL_RUN && cur.sec_o[0]) begin
            case (sel)
                SEL_HR:  if (di == DIG_HR_O  || di == DIG_HR_T)  code = CODE_BLANK;
                SEL_MIN: if (di == DIG_MIN_O || di == DIG_MIN_T) code = CODE_BLANK;
                SEL_SEC: if (di == DIG_SEC_O || di == DIG_SEC_T) code = CODE_BLANK;
                default: ;
            endcase
        end
`endif
    end

    seg7_decode u_dec (
        .code(code),
        .seg (seg)
    );

    always_comb begin
        en_next    = '1;
        en_next[d] = 1'b0;
        dp_next    = ~(((di == DIG_MIN_O) || (di == DIG_HR_O)) && ~cur.sec_o[0]);
    end

    // Segments, enables and dp share one register stage so they switch together.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bus.SSD <= SEG_BLANK;
            bus.EN  <= '1;
            bus.dp  <= 1'b1;
        end else begin
            bus.SSD <= seg;
            bus.EN  <= en_next;
            bus.dp  <= dp_next;
        end
    end

endmodule
